// File: rtl/icache_pkg.sv
// Shared state type, default geometry and address-split width helpers for the instruction cache.
package icache_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH  = 32;
    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_SETS           = 16;
    localparam int unsigned DEF_WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        UPDATE = 2'd2
    } icache_state_e;

    // Address split: {tag, index, offset, 2'b00}
    function automatic int unsigned offset_width(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned index_width(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_width(input int unsigned address_width,
                                              input int unsigned sets,
                                              input int unsigned words_per_line);
        return address_width - $clog2(sets) - $clog2(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill controller: owns the lookup/refill state, beat counter, deferred flush and the
// one-outstanding-request memory handshake.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    localparam int unsigned OFFSET_W = offset_width(WORDS_PER_LINE),
    localparam int unsigned LINE_W   = ADDRESS_WIDTH - OFFSET_W - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss,
    input  logic                     flush,
    input  logic [LINE_W-1:0]        miss_line,
    input  logic                     mem_rvalid,
    output logic                     idle,
    output logic [OFFSET_W-1:0]      beat,
    output logic [LINE_W-1:0]        line,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     fill_we,
    output logic                     update,
    output logic                     set_valid,
    output logic                     clear_valid
);

    icache_state_e         state, state_nxt;
    logic [OFFSET_W-1:0]   beat_nxt;
    logic [LINE_W-1:0]     line_nxt;
    logic                  pend, pend_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            beat  <= '0;
            line  <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            line  <= line_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat;
        line_nxt    = line;
        pend_nxt    = pend;
        mem_req     = 1'b0;
        fill_we     = 1'b0;
        update      = 1'b0;
        set_valid   = 1'b0;
        clear_valid = 1'b0;
        case (state)
            IDLE: begin
                clear_valid = flush;
                if (miss) begin
                    state_nxt = REFILL;
                    beat_nxt  = '0;
                    line_nxt  = miss_line;
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                if (flush) pend_nxt = 1'b1;
                if (mem_rvalid) begin
                    fill_we  = 1'b1;
                    beat_nxt = beat + OFFSET_W'(1);
                    if (beat == OFFSET_W'(WORDS_PER_LINE - 1)) state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                // A flush seen during the refill leaves the new line invalid and wipes the rest.
                update      = 1'b1;
                clear_valid = pend || flush;
                set_valid   = !(pend || flush);
                pend_nxt    = 1'b0;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign idle     = (state == IDLE);
    assign mem_addr = {line, beat, 2'b00};

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with zero-latency hits and whole-line refill on a miss.
// Define ICACHE_PERF_EN to add the hit_count / miss_count performance counters.
module instr_cache
    import icache_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned SETS           = DEF_SETS,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     stall,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int unsigned OFFSET_W = offset_width(WORDS_PER_LINE);
    localparam int unsigned INDEX_W  = index_width(SETS);
    localparam int unsigned TAG_W    = tag_width(ADDRESS_WIDTH, SETS, WORDS_PER_LINE);
    localparam int unsigned LINE_W   = INDEX_W + TAG_W;

    logic [OFFSET_W-1:0]   offset;
    logic [INDEX_W-1:0]    index;
    logic [TAG_W-1:0]      tag;
    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tags [SETS];
    logic [DATA_WIDTH-1:0] data [SETS][WORDS_PER_LINE];
    logic                  idle, lookup_hit, hit, miss;
    logic [OFFSET_W-1:0]   beat;
    logic [LINE_W-1:0]     line;
    logic [INDEX_W-1:0]    fill_index;
    logic [TAG_W-1:0]      fill_tag;
    logic                  fill_we, update, set_valid, clear_valid;
    logic                  unused_pc;

    assign offset     = pc[OFFSET_W+1:2];
    assign index      = pc[OFFSET_W+2 +: INDEX_W];
    assign tag        = pc[ADDRESS_WIDTH-1 -: TAG_W];
    assign unused_pc  = ^pc[1:0];
    assign fill_index = line[INDEX_W-1:0];
    assign fill_tag   = line[LINE_W-1 -: TAG_W];

    // A flush in the lookup cycle forces a miss.
    assign lookup_hit = valid[index] && (tags[index] == tag) && !flush;
    assign hit        = idle && lookup_hit;
    assign miss       = !lookup_hit;
    assign stall      = !hit;
    assign instr      = data[index][offset];

    icache_refill_fsm #(
        .ADDRESS_WIDTH  (ADDRESS_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_refill_fsm (
        .clk         (clk),
        .rst         (rst),
        .miss        (miss),
        .flush       (flush),
        .miss_line   (pc[ADDRESS_WIDTH-1 -: LINE_W]),
        .mem_rvalid  (mem_rvalid),
        .idle        (idle),
        .beat        (beat),
        .line        (line),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .fill_we     (fill_we),
        .update      (update),
        .set_valid   (set_valid),
        .clear_valid (clear_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (clear_valid) begin
            valid <= '0;
        end else if (set_valid) begin
            valid[fill_index] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_we) data[fill_index][beat] <= mem_rdata;
        if (update)  tags[fill_index]       <= fill_tag;
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit)          hit_count  <= hit_count + 32'd1;
            if (idle && miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Bench for instr_cache: a fetch table plus hand-written flush/reset/stray-rvalid sequences,
// against a fixed-latency backing memory with expected data and addresses queued ahead.
module tb_instr_cache;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int LAT      = 3;
    localparam int MISS_CYC = 4 * LAT + 2;
    localparam int BUDGET   = 200;
    localparam int NVEC     = 15;

    logic          clk, rst, flush, stall, mem_req, mem_rvalid, inj;
    logic [AW-1:0] pc, mem_addr;
    logic [DW-1:0] instr, mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0]   hit_count, miss_count;
`endif

    int          total, bad, lat_cnt;
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_addr_q[$];

    typedef struct {
        logic [31:0] pc;
        int          refills;
        int          flush_at;
    } vec_t;
    vec_t tbl[NVEC];

    instr_cache #(
        .ADDRESS_WIDTH  (32),
        .DATA_WIDTH     (32),
        .SETS           (16),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .flush      (flush),
        .instr      (instr),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: answers a held request on its LAT-th cycle; inj forces a stray beat.
    always @(posedge clk) begin
        if (!mem_req || mem_rvalid) lat_cnt <= 0;
        else                        lat_cnt <= lat_cnt + 1;
    end
    assign mem_rvalid = (mem_req && (lat_cnt == LAT - 1)) || inj;
    assign mem_rdata  = inj ? 32'hDEAD_BEEF : memword(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && mem_req && mem_rvalid) begin
            if (exp_addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mem_addr_unexpected: got 0x%08h expected no request", mem_addr);
            end else begin
                check("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
        end
    end

    // Called at the start of a cycle; returns at the start of the cycle after the hit.
    task automatic fetch(input logic [31:0] a, input int refills, input int flush_at,
                         input string name);
        int          c;
        bit          got;
        logic [31:0] got_instr, got_req;
        pc = a;
        exp_instr_q.push_back(memword({a[31:2], 2'b00}));
        for (int r = 0; r < refills; r++)
            for (int k = 0; k < 4; k++)
                exp_addr_q.push_back({a[31:4], 4'h0} + 32'(4 * k));
        c = 0;
        got = 1'b0;
        got_instr = '0;
        got_req = '0;
        while (!got && c < BUDGET) begin
            flush = (c == flush_at);
            @(negedge clk);
            if (!stall) begin
                got       = 1'b1;
                got_instr = instr;
                got_req   = 32'(mem_req);
            end else begin
                c++;
            end
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        check({name, "_stall_cycles"}, 32'(c), 32'(refills * MISS_CYC));
        check({name, "_instr"}, got_instr, exp_instr_q.pop_front());
        check({name, "_mem_req"}, got_req, 32'd0);
        check({name, "_beats_left"}, 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad = 0;
        lat_cnt = 0;
        rst = 1'b0;
        pc = '0;
        flush = 1'b0;
        inj = 1'b0;

        tbl[0]  = '{32'h000, 1, -1};
        tbl[1]  = '{32'h004, 0, -1};
        tbl[2]  = '{32'h008, 0, -1};
        tbl[3]  = '{32'h00C, 0, -1};
        tbl[4]  = '{32'h100, 1, -1};
        tbl[5]  = '{32'h10C, 0, -1};
        tbl[6]  = '{32'h000, 1, -1};
        tbl[7]  = '{32'h014, 1, -1};
        tbl[8]  = '{32'h004, 0, -1};
        tbl[9]  = '{32'h018, 0, -1};
        tbl[10] = '{32'h008, 1,  0};
        tbl[11] = '{32'h010, 1, -1};
        tbl[12] = '{32'h3FC, 1, -1};
        tbl[13] = '{32'h3F0, 0, -1};
        tbl[14] = '{32'h000, 0, -1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            fetch(tbl[i].pc, tbl[i].refills, tbl[i].flush_at,
                  $sformatf("v%0d_pc%0h", i, tbl[i].pc));
`ifdef ICACHE_PERF_EN
            if (i == 3) begin
                check("hit_count", hit_count, 32'd4);
                check("miss_count", miss_count, 32'd1);
            end
`endif
        end

        // Stray memory beat while idle must not touch the arrays or the state.
        pc  = 32'h3F4;
        inj = 1'b1;
        @(negedge clk);
        check("idle_rvalid_stall", 32'(stall), 32'd0);
        check("idle_rvalid_instr", instr, memword(32'h3F4));
        @(posedge clk);
        #1;
        inj = 1'b0;
        fetch(32'h3F0, 0, -1, "post_rvalid_3f0");
        fetch(32'h3F8, 0, -1, "post_rvalid_3f8");
        fetch(32'h000, 0, -1, "post_rvalid_000");
        fetch(32'h050, 1, -1, "post_rvalid_miss");

        // Flush on the second beat: line completes but stays invalid, so it refills again.
        fetch(32'h040, 2, 6, "flush_mid_refill");
        fetch(32'h004, 1, -1, "after_flush_004");

        // Reset in the middle of a refill.
        pc = 32'h020;
        exp_addr_q.push_back(32'h020);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrefill_rst_mem_req", 32'(mem_req), 32'd0);
        check("midrefill_rst_stall", 32'(stall), 32'd1);
        @(negedge clk);
        check("midrefill_rst_mem_addr", mem_addr, 32'd0);
        check("midrefill_first_beat_seen", 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        fetch(32'h000, 1, -1, "after_rst_000");
        fetch(32'h020, 1, -1, "after_rst_020");
        fetch(32'h024, 0, -1, "after_rst_024");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: width of pc and mem_addr.
REQ-002 Parameter DATA_WIDTH, default 32: instruction and memory word width.
REQ-003 Parameter SETS, default 16: number of direct-mapped lines; power of two, at least 2.
REQ-004 Parameter WORDS_PER_LINE, default 4: words per line; power of two, at least 2.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 pc  in  ADDRESS_WIDTH  fetch address from the PC stage; bits [1:0] are ignored.
REQ-008 flush  in  1  invalidate all lines (fence.i).
REQ-009 instr  out  DATA_WIDTH  fetched instruction; meaningful only when stall=0.
REQ-010 stall  out  1  high while instr is not valid for pc; drives the PC stage en_n.
REQ-011 mem_req  out  1  backing-memory read request.
REQ-012 mem_addr  out  ADDRESS_WIDTH  word-aligned read address.
REQ-013 mem_rvalid  in  1  backing memory returns mem_rdata this cycle.
REQ-014 mem_rdata  in  DATA_WIDTH  read data.

Function
REQ-015 The address splits into offset = pc[log2(WORDS_PER_LINE)+1:2], index (next log2(SETS) bits) and tag (remaining upper bits).
REQ-016 FSM states: IDLE, REFILL, UPDATE.
REQ-017 IDLE hit, when valid[index] is set and the stored tag matches: instr = line word[offset] combinationally in the same cycle, with stall = 0.
REQ-018 IDLE miss: stall = 1 in the same cycle; the next state is REFILL; the beat counter is cleared and the miss address is latched.
REQ-019 REFILL handshake: mem_req = 1 and mem_addr = {tag, index, beat, 2'b00}, held stable until mem_rvalid; one request is outstanding at a time.
REQ-020 REFILL sequencing: each mem_rvalid writes mem_rdata into word[beat] and increments beat; the beat counter wraps after WORDS_PER_LINE-1.
REQ-021 REFILL exit: when the last beat returns, the next state is UPDATE and mem_req drops in that same cycle.
REQ-022 UPDATE writes the tag and sets valid[index], with stall = 1, then returns to IDLE; the lookup then hits.
REQ-023 Miss penalty is the sum of the WORDS_PER_LINE memory latencies plus 2 cycles; the hit latency is 0.
REQ-024 stall = 1 in REFILL and UPDATE regardless of pc; pc changes during those states are ignored until IDLE.
REQ-025 flush in IDLE clears every valid bit at the next edge; a lookup in the same cycle as flush is forced to miss.
REQ-026 flush in REFILL or UPDATE sets a pending flag; the refill completes, but UPDATE does not set valid, and all valid bits clear on entry to IDLE.
REQ-027 mem_rvalid outside REFILL is ignored.

Reset
REQ-028 While rst = 0: FSM = IDLE, all valid bits = 0, beat = 0, pending flush = 0, and mem_req = 0 immediately (asynchronously).
REQ-029 Assertion of rst mid-REFILL abandons the refill; no partial line becomes valid.
REQ-030 After reset the first lookup always misses; stall = 1 for any pc; mem_addr = 0.
REQ-031 Data and tag arrays are not reset.

Configuration
REQ-032 Macro ICACHE_PERF_EN: when defined, adds outputs hit_count and miss_count, each 32 bits.
REQ-033 With ICACHE_PERF_EN, hit_count increments per IDLE cycle with a hit and miss_count increments per IDLE-to-REFILL transition; both counters wrap modulo 2^32 and reset to 0.
REQ-034 Without ICACHE_PERF_EN, those ports and counters do not exist, and the behaviour is otherwise identical.

Structure
REQ-035 Shared package icache_pkg holds the FSM state enum (IDLE, REFILL, UPDATE) and localparams for the offset/index/tag widths derived from the parameters.
REQ-036 One sub-module, icache_refill_fsm, owns the state, beat counter, pending flush and memory handshake.
REQ-037 Tag, valid and data arrays live in instr_cache.

Verification
REQ-038 Reset, then pc=0x00000000 with a 3-cycle memory latency -> stall=1, mem_addr sequence 0x0,0x4,0x8,0xC, stall=0 after 3*4+2 cycles, instr equal to the word at 0x0.
REQ-039 After that refill, pc=0x4, 0x8, 0xC on consecutive cycles -> stall=0 each cycle and the correct words with no mem_req; with ICACHE_PERF_EN, hit_count=4 and miss_count=1.
REQ-040 Conflict: pc=0x100 (same index, different tag, SETS=16) -> miss and refill from 0x100; pc=0x0 then misses again.
REQ-041 flush asserted on the second refill beat -> refill completes; the next lookup of the same pc misses and mem_req reasserts.
REQ-042 rst driven low mid-REFILL -> mem_req=0 at once; after release, pc=0x0 misses.
REQ-043 mem_rvalid pulsed in IDLE with arbitrary data -> no array or state change.
